// File: rtl/mips_pkg.sv
// Shared constants and the fetch-state encoding for the MIPS pipeline front end.
package mips_pkg;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam int          PC_INC    = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush and bubble both inject NOP; flush wins over load.
module if_id_reg #(
  parameter int                 PC_W    = 16,
  parameter int                 INSTR_W = 16,
  parameter logic [INSTR_W-1:0] NOP     = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               bubble,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc_plus,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc_plus,
  output logic               id_valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr   <= NOP;
      id_pc_plus <= '0;
      id_valid   <= 1'b0;
    end else if (flush || bubble) begin
      // pc_plus is left as-is: it carries no meaning while valid is low
      id_instr <= NOP;
      id_valid <= 1'b0;
    end else if (load) begin
      id_instr   <= instr;
      id_pc_plus <= pc_plus;
      id_valid   <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack handshake, stall hold buffer and branch drain.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                 PC_W     = 16,
  parameter int                 INSTR_W  = 16,
  parameter logic [PC_W-1:0]    RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP      = NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PC_EN,
  input  logic               IF2ID_EN,
  input  logic               BR_TAKEN,
  input  logic [PC_W-1:0]    BR_TARGET,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [PC_W-1:0]    IF_ID_pc_plus,
  output logic               IF_ID_valid
);
  fetch_state_e       state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] hold_buf;
  logic               hold_vld;

  logic               advance;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    target;
  logic               ld, bub, fl;
  logic [INSTR_W-1:0] din;

  assign advance = PC_EN & IF2ID_EN;
  assign pc_inc  = pc + PC_W'(PC_INC);
  assign target  = {BR_TARGET[PC_W-1:1], 1'b0};

  // In FETCH the PC always equals imem_addr, so pc_inc is the outstanding fetch's PC+2.
  always_comb begin
    ld  = 1'b0;
    bub = 1'b0;
    fl  = 1'b0;
    din = imem_rdata;
    unique case (state)
      S_IDLE:  fl = BR_TAKEN;
      S_FETCH: begin
        if (BR_TAKEN)                  fl  = 1'b1;
        else if (imem_ack && advance)  ld  = 1'b1;
        else                           bub = IF2ID_EN;
      end
      S_HOLD: begin
        din = hold_buf;
        if (BR_TAKEN)                 fl = 1'b1;
        else if (advance && hold_vld) ld = 1'b1;
      end
      S_DRAIN: begin
        if (BR_TAKEN) fl  = 1'b1;
        else          bub = IF2ID_EN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
      hold_buf  <= NOP;
      hold_vld  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state     <= S_FETCH;
          imem_req  <= 1'b1;
          pc        <= BR_TAKEN ? target : pc;
          imem_addr <= BR_TAKEN ? target : pc;
        end
        S_FETCH: begin
          if (BR_TAKEN) begin
            pc       <= target;
            hold_vld <= 1'b0;
            if (imem_ack) imem_addr <= target;
            else          state     <= S_DRAIN;  // stale request must still complete
          end else if (imem_ack) begin
            if (advance) begin
              pc        <= pc_inc;
              imem_addr <= pc_inc;
            end else begin
              hold_buf <= imem_rdata;
              hold_vld <= 1'b1;
              imem_req <= 1'b0;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (BR_TAKEN) begin
            pc        <= target;
            imem_addr <= target;
            hold_vld  <= 1'b0;
            imem_req  <= 1'b1;
            state     <= S_FETCH;
          end else if (advance && hold_vld) begin
            pc        <= pc_inc;
            imem_addr <= pc_inc;
            hold_vld  <= 1'b0;
            imem_req  <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (BR_TAKEN) pc <= target;
          if (imem_ack) begin
            imem_addr <= BR_TAKEN ? target : pc;
            state     <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .NOP     (NOP)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ld),
    .bubble     (bub),
    .flush      (fl),
    .instr      (din),
    .pc_plus    (pc_inc),
    .id_instr   (IF_ID_instr),
    .id_pc_plus (IF_ID_pc_plus),
    .id_valid   (IF_ID_valid)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, corner sequences, and randomized run vs a transaction model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_en, if2id_en, br_taken, imem_ack;
  logic [15:0] br_target, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [15:0] imem_addr, if_id_instr, if_id_pc_plus;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC_EN         (pc_en),
    .IF2ID_EN      (if2id_en),
    .BR_TAKEN      (br_taken),
    .BR_TARGET     (br_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .IF_ID_instr   (if_id_instr),
    .IF_ID_pc_plus (if_id_pc_plus),
    .IF_ID_valid   (if_id_valid)
  );

  int checks = 0, errors = 0, cyc = 0;

  // model: fetch transactions, not FSM states
  bit          m_started, m_req, m_wrong, m_bufv, m_valid;
  logic [15:0] m_pc, m_addr, m_buf, m_instr, m_pcp;
  int          lat, cnt;
  bit          rd_is_addr;

  typedef struct {
    logic        pc_en, if2id, br;
    logic [15:0] tgt;
    logic        req;
    logic [15:0] addr, instr, pcp;
    logic        valid;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    m_started = 0; m_req = 0; m_wrong = 0; m_bufv = 0; m_valid = 0;
    m_pc = 16'h0; m_addr = 16'h0; m_buf = 16'h0; m_instr = 16'h0; m_pcp = 16'h0;
    cnt = 0;
  endtask

  task automatic m_bubble();
    if (if2id_en) begin m_instr = 16'h0; m_valid = 0; end
  endtask

  task automatic m_flush();
    m_instr = 16'h0; m_valid = 0;
  endtask

  task automatic m_step();
    logic [15:0] t;
    bit adv;
    t   = {br_target[15:1], 1'b0};
    adv = pc_en && if2id_en;
    if (!m_started) begin
      m_started = 1;
      if (br_taken) begin m_pc = t; m_flush(); end
      m_req = 1; m_addr = m_pc;
    end else if (m_bufv) begin
      if (br_taken) begin
        m_pc = t; m_bufv = 0; m_flush(); m_req = 1; m_addr = m_pc;
      end else if (adv) begin
        m_instr = m_buf; m_pcp = m_pc + 16'd2; m_valid = 1;
        m_pc = m_pc + 16'd2; m_bufv = 0; m_req = 1; m_addr = m_pc;
      end
    end else if (br_taken) begin
      m_pc = t; m_flush();
      if (imem_ack) begin m_wrong = 0; m_addr = m_pc; end
      else m_wrong = 1;
    end else if (imem_ack) begin
      if (m_wrong) begin
        m_wrong = 0; m_addr = m_pc; m_bubble();
      end else if (adv) begin
        m_instr = imem_rdata; m_pcp = m_pc + 16'd2; m_valid = 1;
        m_pc = m_pc + 16'd2; m_addr = m_pc;
      end else begin
        m_buf = imem_rdata; m_bufv = 1; m_req = 0; m_bubble();
      end
    end else m_bubble();
  endtask

  // Called at a negedge: check, drive memory, take one edge, update model.
  task automatic cycle();
    bit req_s;
    chk("req",    {15'h0, imem_req},    {15'h0, m_req});
    chk("addr",   imem_addr,            m_addr);
    chk("instr",  if_id_instr,          m_instr);
    chk("pcplus", if_id_pc_plus,        m_pcp);
    chk("valid",  {15'h0, if_id_valid}, {15'h0, m_valid});
    req_s = imem_req;
    if (!imem_req)     imem_ack = 1'b0;
    else if (lat == 0) imem_ack = ($urandom_range(0, 2) != 0);
    else               imem_ack = (cnt >= lat - 1);
    imem_rdata = (imem_ack && rd_is_addr) ? imem_addr : 16'($urandom);
    @(posedge clk);
    m_step();
    if (imem_ack) cnt = 0;
    else if (req_s) cnt++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic nominal();
    pc_en = 1; if2id_en = 1; br_taken = 0; br_target = 16'h0;
  endtask

  task automatic do_reset(input int l);
    nominal();
    imem_ack = 0; imem_rdata = 16'h0;
    rst_n = 0; m_reset(); lat = l;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  function automatic vec_t mk(input logic br, input logic [15:0] tgt, input logic req,
                              input logic [15:0] addr, input logic [15:0] instr,
                              input logic [15:0] pcp, input logic valid);
    vec_t v;
    v.pc_en = 1; v.if2id = 1; v.br = br; v.tgt = tgt;
    v.req = req; v.addr = addr; v.instr = instr; v.pcp = pcp; v.valid = valid;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(0, 16'h0,    0, 16'h0000, 16'h0000, 16'h0000, 0);
    tbl[1] = mk(0, 16'h0,    1, 16'h0000, 16'h0000, 16'h0000, 0);
    tbl[2] = mk(0, 16'h0,    1, 16'h0002, 16'h0000, 16'h0002, 1);
    tbl[3] = mk(0, 16'h0,    1, 16'h0004, 16'h0002, 16'h0004, 1);
    tbl[4] = mk(0, 16'h0,    1, 16'h0006, 16'h0004, 16'h0006, 1);
    tbl[5] = mk(1, 16'h0041, 1, 16'h0008, 16'h0006, 16'h0008, 1);
    tbl[6] = mk(0, 16'h0,    1, 16'h0040, 16'h0000, 16'h0008, 0);
    tbl[7] = mk(0, 16'h0,    1, 16'h0042, 16'h0040, 16'h0042, 1);

    // Table: single-cycle ack streaming, then a taken branch with odd target
    rd_is_addr = 1;
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      chk("tbl_req",    {15'h0, imem_req},    {15'h0, tbl[i].req});
      chk("tbl_addr",   imem_addr,            tbl[i].addr);
      chk("tbl_instr",  if_id_instr,          tbl[i].instr);
      chk("tbl_pcplus", if_id_pc_plus,        tbl[i].pcp);
      chk("tbl_valid",  {15'h0, if_id_valid}, {15'h0, tbl[i].valid});
      pc_en = tbl[i].pc_en; if2id_en = tbl[i].if2id;
      br_taken = tbl[i].br; br_target = tbl[i].tgt;
      cycle();
    end

    // Stall during the ack at 0x0010
    do_reset(1);
    begin
      int n = 0;
      while (imem_addr != 16'h0010 && n < 20) begin cycle(); n++; end
      chk("stall_reach", {15'h0, n < 20}, 16'h1);
    end
    pc_en = 0; if2id_en = 0;
    cycle();
    chk("hold_req",   {15'h0, imem_req}, 16'h0);
    chk("hold_instr", if_id_instr,       16'h000E);
    cycle(); cycle();
    chk("hold_frozen", if_id_instr,       16'h000E);
    chk("hold_req2",   {15'h0, imem_req}, 16'h0);
    nominal();
    cycle();
    chk("rel_instr", if_id_instr,   16'h0010);
    chk("rel_pcp",   if_id_pc_plus, 16'h0012);
    chk("rel_addr",  imem_addr,     16'h0012);
    cycle();
    chk("rel_next", if_id_instr, 16'h0012);

    // Branch mid-request with 3-cycle ack latency
    do_reset(3);
    cycle(); cycle();
    br_taken = 1; br_target = 16'h0040;
    cycle();
    nominal();
    chk("drain_addr",  imem_addr,            16'h0000);
    chk("drain_req",   {15'h0, imem_req},    16'h1);
    chk("drain_valid", {15'h0, if_id_valid}, 16'h0);
    cycle();
    chk("drain_redir", imem_addr,            16'h0040);
    chk("drain_drop",  {15'h0, if_id_valid}, 16'h0);
    cycle(); cycle();
    chk("drain_wait", {15'h0, if_id_valid}, 16'h0);
    cycle();
    chk("drain_tgt", if_id_instr, 16'h0040);

    // Branch together with ack and stall, then wrap at 0xFFFE
    do_reset(1);
    cycle(); cycle(); cycle();
    pc_en = 0; if2id_en = 0; br_taken = 1; br_target = 16'h0040;
    cycle();
    nominal();
    chk("bas_instr", if_id_instr,            16'h0000);
    chk("bas_valid", {15'h0, if_id_valid},   16'h0);
    chk("bas_addr",  imem_addr,              16'h0040);
    br_taken = 1; br_target = 16'hFFFE;
    cycle();
    nominal();
    chk("wrap_tgt", imem_addr, 16'hFFFE);
    cycle();
    chk("wrap_addr", imem_addr,     16'h0000);
    chk("wrap_pcp",  if_id_pc_plus, 16'h0000);
    chk("wrap_ins",  if_id_instr,   16'hFFFE);

    // Reset asserted while draining
    do_reset(3);
    cycle(); cycle(); cycle(); cycle();
    br_taken = 1; br_target = 16'h0080;
    cycle();
    nominal();
    #2 rst_n = 0;
    #1;
    chk("rst_req",   {15'h0, imem_req},    16'h0);
    chk("rst_addr",  imem_addr,            16'h0000);
    chk("rst_instr", if_id_instr,          16'h0000);
    chk("rst_pcp",   if_id_pc_plus,        16'h0000);
    chk("rst_valid", {15'h0, if_id_valid}, 16'h0);
    m_reset(); imem_ack = 0;
    @(negedge clk);
    rst_n = 1;
    cycle(); cycle();
    chk("rst_restart", imem_addr, 16'h0000);
    for (int i = 0; i < 6; i++) cycle();

    // Randomized against the model
    rd_is_addr = 0;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(seg % 3);
      for (int i = 0; i < 600; i++) begin
        pc_en     = ($urandom_range(0, 4) != 0);
        if2id_en  = ($urandom_range(0, 4) != 0);
        br_taken  = ($urandom_range(0, 9) == 0);
        br_target = (seg == 3) ? 16'hFFFE : 16'($urandom);
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the PC, issues requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register that the ID stage and hazard unit consume. It obeys the hazard unit's `PC_EN`/`IF2ID_EN` stall controls and the ID-stage branch redirect, flushing and draining wrong-path fetches.

## Interface
Parameters:
- `PC_W`, 16, PC and imem address width (byte address).
- `INSTR_W`, 16, instruction width.
- `RESET_PC`, 16'h0000, PC value after reset.
- `NOP`, 16'h0000, instruction word injected on bubble or flush.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `PC_EN`  in  1  hazard unit: 0 = PC must not advance.
- `IF2ID_EN`  in  1  hazard unit: 0 = IF/ID register holds.
- `BR_TAKEN`  in  1  ID stage: taken branch or BNE, redirect this cycle.
- `BR_TARGET`  in  PC_W  redirect address.
- `imem_req`  out  1  request valid; held until `imem_ack`.
- `imem_addr`  out  PC_W  request address; stable while `imem_req`=1.
- `imem_ack`  in  1  data valid on `imem_rdata` for the outstanding request.
- `imem_rdata`  in  INSTR_W  fetched instruction.
- `IF_ID_instr`  out  INSTR_W  IF/ID instruction.
- `IF_ID_pc_plus`  out  PC_W  IF/ID PC+2 of that instruction.
- `IF_ID_valid`  out  1  IF/ID holds a real instruction.

## Operation
- `advance` = `PC_EN` & `IF2ID_EN`.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE (reset state): `imem_req`=0; next cycle goes to FETCH with `imem_addr`=PC.
- FETCH: `imem_req`=1.
  - `imem_ack` & `advance`: IF/ID gets rdata, PC+2, valid=1; PC and `imem_addr` both become PC+2; stay in FETCH.
  - `imem_ack` & !`advance`: rdata goes to the hold buffer; go to HOLD.
  - No ack: if `IF2ID_EN`=1, load a bubble (`NOP`, valid=0); otherwise IF/ID holds.
- HOLD: `imem_req`=0. On `advance`, load IF/ID from the hold buffer (valid=1), advance PC by 2, go to FETCH. Otherwise IF/ID and the buffer hold.
- `BR_TAKEN` has priority over stall and ack in every state:
  - PC becomes `BR_TARGET`.
  - IF/ID is flushed (`NOP`, valid=0) and the hold buffer is invalidated.
  - FETCH with ack in the same cycle, or HOLD: data is dropped, `imem_addr` becomes `BR_TARGET`, go to FETCH.
  - FETCH without ack: go to DRAIN. `imem_addr` keeps the stale address.
  - IDLE: PC still loads `BR_TARGET`.
- DRAIN: `imem_req`=1 at the stale address. On ack, drop the data, set `imem_addr` to PC, go to FETCH. A further `BR_TAKEN` in DRAIN updates PC and stays in DRAIN.
- PC arithmetic is modulo 2^PC_W: 0xFFFE + 2 = 0x0000, with no flag. `BR_TARGET` bit 0 is forced to 0.

## Timing
- Reset (async, immediate): state=IDLE, PC=`imem_addr`=`RESET_PC`, `imem_req`=0, `IF_ID_instr`=`NOP`, `IF_ID_pc_plus`=0, `IF_ID_valid`=0, hold buffer invalid.
- Reset mid-transaction aborts any outstanding request. Memory is reset by the same `rst_n`.
- `imem_req` is asserted one cycle after reset release.
- With single-cycle ack, IF/ID receives the instruction at `imem_addr` on the edge of the ack cycle, and the next request issues the following cycle. Sustained throughput is 1 instruction/cycle.
- Branch penalty: one flushed slot, plus the remaining ack latency if in DRAIN.
- `imem_addr` changes only on the edge where ack is sampled, or when leaving IDLE or HOLD.

## Structure
- `mips_pkg`: `NOP`, `PC_INC`=2, fetch state enum.
- Sub-module `if_id_reg`: enable, flush and load-bubble controls; async active-low reset.
- `fetch_stage` contains the FSM, PC, address register and hold buffer.

## Test plan
- Reset release, ack always 1, rdata = address: IF/ID shows 0x0000, 0x0002, 0x0004 on consecutive cycles with valid=1 and pc_plus = addr+2.
- `PC_EN`=`IF2ID_EN`=0 for 3 cycles during an ack at 0x0010: state HOLD, `imem_req`=0, IF/ID frozen. After release, IF/ID=0x0010, then fetch resumes at 0x0012.
- Ack latency 3, `BR_TAKEN` with `BR_TARGET`=0x0040 mid-request: DRAIN holds the stale address until ack, the data is dropped, the next request is 0x0040, and IF/ID valid=0 throughout.
- `BR_TAKEN` asserted together with ack and stall: branch wins, IF/ID flushed to `NOP`, next `imem_addr`=0x0040.
- PC at 0xFFFE: the next fetch address is 0x0000.
- `rst_n` pulled low while in DRAIN: all outputs return to reset values immediately, and fetch restarts at `RESET_PC`.
